// File: rtl/uart_tx_chunk_arbiter.sv
`default_nettype none
//==========================================================================
// Module : uart_tx_chunk_arbiter
// Round-robin capture/kick scheduler sharing one chunker among producers.
// Optional feature macro: CHUNK_ARB_TYPE_CHECK_EN (drop invalid chunks).
// Rev    : 1.0
//==========================================================================
module uart_tx_chunk_arbiter #(
   parameter int NUM_CHANNELS             = 2,
   parameter int CHANNEL_INDEX_SIZE       = 1,
   parameter int CONTENT_BUFFER_BYTE_SIZE = 3,
   parameter int BUFFER_INDEX_SIZE        = 32,
   parameter int BUSY_TIMEOUT             = 4
) (
   input  logic                                             CLK,
   input  logic                                             RST,
   input  logic [NUM_CHANNELS-1:0]                          req,
   input  logic [NUM_CHANNELS*BUFFER_INDEX_SIZE-1:0]        req_sizes,
   input  logic [NUM_CHANNELS*CONTENT_BUFFER_BYTE_SIZE*8-1:0] req_bytes,
   input  logic [NUM_CHANNELS*8-1:0]                        req_types,
   input  logic                                             chunker_done,
`ifdef CHUNK_ARB_TYPE_CHECK_EN
   output logic                                             drop_pulse,
   output logic [15:0]                                      drop_count,
`endif
   output logic [NUM_CHANNELS-1:0]                          ack,
   output logic [CHANNEL_INDEX_SIZE-1:0]                    grant_id,
   output logic                                             busy,
   output logic                                             chunk_ready,
   output logic [BUFFER_INDEX_SIZE-1:0]                     chunk_byte_size,
   output logic [CONTENT_BUFFER_BYTE_SIZE*8-1:0]            chunk_bytes,
   output logic [7:0]                                       chunk_type
);

   localparam int c_BYTES_W = CONTENT_BUFFER_BYTE_SIZE * 8;
   localparam int c_CNT_W   = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [c_CNT_W-1:0]            c_TO_LAST  = c_CNT_W'(BUSY_TIMEOUT - 1);
   localparam logic [CHANNEL_INDEX_SIZE-1:0] c_LAST_CH  = CHANNEL_INDEX_SIZE'(NUM_CHANNELS - 1);
   localparam logic [NUM_CHANNELS-1:0]       c_ONE      = NUM_CHANNELS'(1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_KICK      = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t                          r_state;
   state_t                          w_next_state;
   logic [CHANNEL_INDEX_SIZE-1:0]   r_rr_ptr;
   logic [NUM_CHANNELS-1:0]         r_ack;
   logic [CHANNEL_INDEX_SIZE-1:0]   r_grant_id;
   logic                            r_busy;
   logic                            r_chunk_ready;
   logic [BUFFER_INDEX_SIZE-1:0]    r_size;
   logic [c_BYTES_W-1:0]            r_bytes;
   logic [7:0]                      r_type;
   logic [c_CNT_W-1:0]              r_cnt;

   logic                            w_hit_hi;
   logic [CHANNEL_INDEX_SIZE-1:0]   w_win_hi;
   logic [CHANNEL_INDEX_SIZE-1:0]   w_win_lo;
   logic [CHANNEL_INDEX_SIZE-1:0]   w_winner;
   logic [CHANNEL_INDEX_SIZE-1:0]   w_rr_next;
   logic [NUM_CHANNELS-1:0]         w_onehot;
   logic [BUFFER_INDEX_SIZE-1:0]    w_sel_size;
   logic [c_BYTES_W-1:0]            w_sel_bytes;
   logic [7:0]                      w_sel_type;
   logic                            w_valid;
   logic                            w_grant;

   // Lowest set request at or above rr_ptr wins; otherwise wrap to the lowest set request.
   always_comb begin
      w_hit_hi = 1'b0;
      w_win_hi = '0;
      w_win_lo = '0;
      for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
         if (req[i]) begin
            w_win_lo = CHANNEL_INDEX_SIZE'(i);
         end
         if (req[i] && (CHANNEL_INDEX_SIZE'(i) >= r_rr_ptr)) begin
            w_hit_hi = 1'b1;
            w_win_hi = CHANNEL_INDEX_SIZE'(i);
         end
      end
      w_winner  = w_hit_hi ? w_win_hi : w_win_lo;
      w_rr_next = (w_winner == c_LAST_CH) ? '0 : w_winner + 1'b1;
      w_onehot  = c_ONE << w_winner;
   end

   always_comb begin
      w_sel_size  = '0;
      w_sel_bytes = '0;
      w_sel_type  = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (w_winner == CHANNEL_INDEX_SIZE'(i)) begin
            w_sel_size  = req_sizes[i*BUFFER_INDEX_SIZE +: BUFFER_INDEX_SIZE];
            w_sel_bytes = req_bytes[i*c_BYTES_W +: c_BYTES_W];
            w_sel_type  = req_types[i*8 +: 8];
         end
      end
   end

`ifdef CHUNK_ARB_TYPE_CHECK_EN
   assign w_valid = (w_sel_type != 8'd0) && (w_sel_size != '0) &&
                    (w_sel_size <= BUFFER_INDEX_SIZE'(CONTENT_BUFFER_BYTE_SIZE));
`else
   assign w_valid = 1'b1;
`endif

   always_comb begin
      w_next_state = r_state;
      w_grant      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if ((|req) && chunker_done) begin
               w_grant = 1'b1;
               if (w_valid) begin
                  w_next_state = S_KICK;
               end
            end
         end
         S_KICK: w_next_state = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            // A chunker that never leaves idle loses the chunk; no retry.
            if (!chunker_done) begin
               w_next_state = S_WAIT_DONE;
            end else if (r_cnt == c_TO_LAST) begin
               w_next_state = S_IDLE;
            end
         end
         S_WAIT_DONE: begin
            if (chunker_done) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state       <= S_IDLE;
         r_rr_ptr      <= '0;
         r_ack         <= '0;
         r_grant_id    <= '0;
         r_busy        <= 1'b0;
         r_chunk_ready <= 1'b0;
         r_size        <= '0;
         r_bytes       <= '0;
         r_type        <= '0;
         r_cnt         <= '0;
      end else begin
         r_state       <= w_next_state;
         r_ack         <= w_grant ? w_onehot : '0;
         r_busy        <= (w_next_state != S_IDLE);
         r_chunk_ready <= (r_state == S_KICK);
         if (w_grant) begin
            r_grant_id <= w_winner;
            r_rr_ptr   <= w_rr_next;
         end
         if (w_grant && w_valid) begin
            r_size  <= w_sel_size;
            r_bytes <= w_sel_bytes;
            r_type  <= w_sel_type;
         end
         if (r_state == S_KICK) begin
            r_cnt <= '0;
         end else if ((r_state == S_WAIT_BUSY) && chunker_done) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

`ifdef CHUNK_ARB_TYPE_CHECK_EN
   logic        r_drop_pulse;
   logic [15:0] r_drop_count;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_drop_pulse <= 1'b0;
         r_drop_count <= '0;
      end else begin
         r_drop_pulse <= w_grant && !w_valid;
         if (w_grant && !w_valid && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
         end
      end
   end

   assign drop_pulse = r_drop_pulse;
   assign drop_count = r_drop_count;
`endif

   assign ack             = r_ack;
   assign grant_id        = r_grant_id;
   assign busy            = r_busy;
   assign chunk_ready     = r_chunk_ready;
   assign chunk_byte_size = r_size;
   assign chunk_bytes     = r_bytes;
   assign chunk_type      = r_type;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_chunk_arbiter.sv
`default_nettype none
//==========================================================================
// Module : tb_uart_tx_chunk_arbiter
// Directed self-checking bench with a small chunker model.
// Rev    : 1.0
//==========================================================================
module tb_uart_tx_chunk_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic [1:0]  req;
   logic [63:0] req_sizes;
   logic [47:0] req_bytes;
   logic [15:0] req_types;
   logic        chunker_done;
   logic [1:0]  ack;
   logic [0:0]  grant_id;
   logic        busy;
   logic        chunk_ready;
   logic [31:0] chunk_byte_size;
   logic [23:0] chunk_bytes;
   logic [7:0]  chunk_type;
`ifdef CHUNK_ARB_TYPE_CHECK_EN
   logic        drop_pulse;
   logic [15:0] drop_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // Chunker model: goes busy for 3 cycles after sampling chunk_ready.
   logic model_done = 1'b1;
   int   model_cnt  = 0;
   logic use_manual = 1'b0;
   logic manual_done = 1'b1;

   assign chunker_done = use_manual ? manual_done : model_done;

   always @(posedge CLK) begin
      if (model_cnt != 0) begin
         model_cnt <= model_cnt - 1;
         if (model_cnt == 1) model_done <= 1'b1;
      end else if (chunk_ready && model_done) begin
         model_done <= 1'b0;
         model_cnt  <= 3;
      end
   end

   always #5 CLK = ~CLK;

   uart_tx_chunk_arbiter dut (
      .CLK             (CLK),
      .RST             (RST),
      .req             (req),
      .req_sizes       (req_sizes),
      .req_bytes       (req_bytes),
      .req_types       (req_types),
      .chunker_done    (chunker_done),
`ifdef CHUNK_ARB_TYPE_CHECK_EN
      .drop_pulse      (drop_pulse),
      .drop_count      (drop_count),
`endif
      .ack             (ack),
      .grant_id        (grant_id),
      .busy            (busy),
      .chunk_ready     (chunk_ready),
      .chunk_byte_size (chunk_byte_size),
      .chunk_bytes     (chunk_bytes),
      .chunk_type      (chunk_type)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_ch(input int ch, input logic [31:0] sz, input logic [23:0] by, input logic [7:0] ty);
      req_sizes[ch*32 +: 32] = sz;
      req_bytes[ch*24 +: 24] = by;
      req_types[ch*8 +: 8]   = ty;
   endtask

   task automatic wait_idle(input string name);
      bit ok = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (busy == 1'b0 && chunker_done == 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s_idle: busy=%b done=%b, required busy=0 done=1 within 30 cycles", name, busy, chunker_done);
      end
   endtask

   task automatic test_reset();
      tick();
      n_cmp++;
      if ({ack, grant_id, busy, chunk_ready} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got ack=%b gid=%b busy=%b rdy=%b, required all 0", ack, grant_id, busy, chunk_ready);
      end
      n_cmp++;
      if ({chunk_byte_size, chunk_bytes, chunk_type} !== 64'h0) begin
         n_bad++;
         $display("FAIL reset_data: got %h/%h/%h, required 0/0/0", chunk_byte_size, chunk_bytes, chunk_type);
      end
      RST = 1'b0;
      tick();
   endtask

   task automatic test_single();
      set_ch(0, 32'd3, 24'h030201, 8'h02);
      req = 2'b01;
      tick(); // E0
      n_cmp++;
      if (ack !== 2'b01 || busy !== 1'b1 || grant_id !== 1'b0 || chunk_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL single_e0: ack=%b busy=%b gid=%b rdy=%b, required 01/1/0/0", ack, busy, grant_id, chunk_ready);
      end
      req = 2'b00;
      set_ch(0, 32'd7, 24'hFFFFFF, 8'hEE);
      tick(); // E0+1
      n_cmp++;
      if (chunk_ready !== 1'b1 || ack !== 2'b00) begin
         n_bad++;
         $display("FAIL single_kick: rdy=%b ack=%b, required 1/00", chunk_ready, ack);
      end
      for (int k = 2; k <= 5; k++) begin
         tick();
         n_cmp++;
         if (chunk_ready !== 1'b0 || busy !== 1'b1 ||
             {chunk_byte_size, chunk_bytes, chunk_type} !== {32'd3, 24'h030201, 8'h02}) begin
            n_bad++;
            $display("FAIL single_hold_e%0d: rdy=%b busy=%b data=%h/%h/%h, required 0/1/3/030201/02",
                     k, chunk_ready, busy, chunk_byte_size, chunk_bytes, chunk_type);
         end
      end
      n_cmp++;
      if (chunker_done !== 1'b1) begin
         n_bad++;
         $display("FAIL single_model_done: got %b, required 1 at E0+5", chunker_done);
      end
      tick(); // E0+6
      n_cmp++;
      if (busy !== 1'b0 || ack !== 2'b00) begin
         n_bad++;
         $display("FAIL single_busy_fall: busy=%b ack=%b, required 0/00", busy, ack);
      end
   endtask

   task automatic test_contention();
      int exp = 0;
      logic [1:0] exp_ack;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      set_ch(0, 32'd1, 24'h111111, 8'h10);
      set_ch(1, 32'd2, 24'h222222, 8'h11);
      req = 2'b11;
      for (int g = 0; g < 4; g++) begin
         bit found = 1'b0;
         for (int c = 0; c < 20; c++) begin
            tick();
            if (ack !== 2'b00) begin
               found = 1'b1;
               break;
            end
         end
         exp_ack = (exp == 0) ? 2'b01 : 2'b10;
         n_cmp++;
         if (!found || ack !== exp_ack || grant_id !== exp[0] || chunk_type !== (8'h10 + 8'(exp))) begin
            n_bad++;
            $display("FAIL contention_g%0d: ack=%b gid=%b type=%h, required %b/%0d/%h",
                     g, ack, grant_id, chunk_type, exp_ack, exp, 8'h10 + 8'(exp));
         end
         req[exp] = 1'b0;
         tick();
         req[exp] = 1'b1;
         exp = 1 - exp;
      end
      req = 2'b00;
      wait_idle("contention");
      tick();
   endtask

   task automatic test_busy_holdoff();
      set_ch(0, 32'd2, 24'h00AABB, 8'h05);
      req = 2'b01;
      tick(); // E0
      n_cmp++;
      if (ack !== 2'b01) begin
         n_bad++;
         $display("FAIL holdoff_ack0: got %b, required 01", ack);
      end
      req = 2'b00;
      set_ch(0, 32'd9, 24'hDEADBE, 8'h77);
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 3) begin
            set_ch(1, 32'd1, 24'h000033, 8'h06);
            req = 2'b10;
         end
         n_cmp++;
         if (ack !== 2'b00 || busy !== (k < 6) ||
             {chunk_byte_size, chunk_bytes, chunk_type} !== {32'd2, 24'h00AABB, 8'h05}) begin
            n_bad++;
            $display("FAIL holdoff_e%0d: ack=%b busy=%b data=%h/%h/%h, required 00/%b/2/00aabb/05",
                     k, ack, busy, chunk_byte_size, chunk_bytes, chunk_type, k < 6);
         end
      end
      tick(); // E0+7
      n_cmp++;
      if (ack !== 2'b10 || grant_id !== 1'b1 || chunk_type !== 8'h06 || chunk_byte_size !== 32'd1) begin
         n_bad++;
         $display("FAIL holdoff_ack1: ack=%b gid=%b type=%h size=%0d, required 10/1/06/1",
                  ack, grant_id, chunk_type, chunk_byte_size);
      end
      req = 2'b00;
      wait_idle("holdoff");
      tick();
   endtask

   task automatic test_timeout();
      use_manual  = 1'b1;
      manual_done = 1'b1;
      set_ch(0, 32'd1, 24'h000044, 8'h07);
      req = 2'b01;
      tick(); // E0
      n_cmp++;
      if (ack !== 2'b01) begin
         n_bad++;
         $display("FAIL timeout_ack: got %b, required 01", ack);
      end
      req = 2'b00;
      tick(); // E0+1
      n_cmp++;
      if (chunk_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL timeout_kick: got %b, required 1", chunk_ready);
      end
      for (int k = 2; k <= 4; k++) begin
         tick();
         n_cmp++;
         if (busy !== 1'b1 || chunk_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_wait_e%0d: busy=%b rdy=%b, required 1/0", k, busy, chunk_ready);
         end
      end
      tick(); // E0+5
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL timeout_release: busy=%b, required 0", busy);
      end
      for (int k = 6; k <= 9; k++) begin
         tick();
         n_cmp++;
         if (chunk_ready !== 1'b0 || ack !== 2'b00) begin
            n_bad++;
            $display("FAIL timeout_quiet_e%0d: rdy=%b ack=%b, required 0/00", k, chunk_ready, ack);
         end
      end
   endtask

   task automatic test_reset_mid();
      set_ch(1, 32'd3, 24'h0C0B0A, 8'h08);
      req = 2'b10;
      tick(); // E0
      n_cmp++;
      if (ack !== 2'b10 || grant_id !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid_ack: ack=%b gid=%b, required 10/1", ack, grant_id);
      end
      req = 2'b00;
      tick();
      tick();
      manual_done = 1'b0;
      tick(); // E0+3: in WAIT_DONE
      #2;
      RST = 1'b1;
      #1;
      n_cmp++;
      if ({ack, grant_id, busy, chunk_ready, chunk_byte_size, chunk_bytes, chunk_type} !== 69'h0) begin
         n_bad++;
         $display("FAIL rstmid_async: ack=%b gid=%b busy=%b rdy=%b data=%h/%h/%h, required all 0",
                  ack, grant_id, busy, chunk_ready, chunk_byte_size, chunk_bytes, chunk_type);
      end
      tick();
      RST = 1'b0;
      set_ch(0, 32'd1, 24'h000055, 8'h09);
      req = 2'b01;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++;
         if (ack !== 2'b00 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_block_%0d: ack=%b busy=%b, required 00/0", k, ack, busy);
         end
      end
      manual_done = 1'b1;
      tick();
      n_cmp++;
      if (ack !== 2'b01 || grant_id !== 1'b0 || chunk_type !== 8'h09) begin
         n_bad++;
         $display("FAIL rstmid_regrant: ack=%b gid=%b type=%h, required 01/0/09", ack, grant_id, chunk_type);
      end
      req = 2'b00;
      wait_idle("rstmid");
      use_manual = 1'b0;
      wait_idle("rstmid_model");
      tick();
   endtask

`ifdef CHUNK_ARB_TYPE_CHECK_EN
   task automatic test_type_drop();
      set_ch(0, 32'd2, 24'h000102, 8'h00);
      set_ch(1, 32'd2, 24'h000102, 8'h00);
      req = 2'b11;
      tick();
      n_cmp++;
      if (ack === 2'b00 || drop_pulse !== 1'b1 || drop_count !== 16'd1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL drop_e0: ack=%b pulse=%b count=%0d busy=%b, required ack!=0/1/1/0",
                  ack, drop_pulse, drop_count, busy);
      end
      req = 2'b00;
      tick();
      n_cmp++;
      if (chunk_ready !== 1'b0 || busy !== 1'b0 || drop_pulse !== 1'b0) begin
         n_bad++;
         $display("FAIL drop_after: rdy=%b busy=%b pulse=%b, required 0/0/0", chunk_ready, busy, drop_pulse);
      end
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      RST       = 1'b1;
      req       = 2'b00;
      req_sizes = '0;
      req_bytes = '0;
      req_types = '0;
      test_reset();
      test_single();
      test_contention();
      test_busy_holdoff();
      test_timeout();
      test_reset_mid();
`ifdef CHUNK_ARB_TYPE_CHECK_EN
      test_type_drop();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
